// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the loadable instruction memory: loader state
// encodings, the bytes-per-word helper and the NOP instruction constant.
// Optional feature macro: IMEM_CHECKSUM_EN adds the CSUM state.
package instr_mem_loader_pkg;

`ifdef IMEM_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6
    } loader_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd6
    } loader_state_t;
`endif

    // NOP encoding of the Colorus instruction set
    localparam logic [27:0] IMEM_NOP = 28'h0;

    // Number of stream bytes that make up one instruction word
    function automatic int bytes_per_word(input int dw);
        return (dw + 7) / 8;
    endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Collects stream bytes little-endian into one instruction word.
// Byte j of a word lands in bits [8j+7:8j]; bits above DATA_WIDTH-1 are
// dropped. byte_last flags the byte that completes a word; word_valid
// pulses the cycle after, when word holds the finished instruction.
module instr_mem_loader_word_assembler
    import instr_mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_last,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid
);

    localparam int BPW = bytes_per_word(DATA_WIDTH);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]         byte_cnt;
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_next;

    assign byte_last = byte_valid && (byte_cnt == CW'(BPW - 1));
    assign word      = word_q;

    // Steer the incoming byte into the lane selected by the byte counter
    always_comb begin
        word_next = word_q;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            if ((j / 8) == int'(byte_cnt)) begin
                word_next[j] = byte_in[j % 8];
            end
        end
    end

    // Byte counter, word register and completion pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt   <= '0;
            word_q     <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_last;
            if (clear) begin
                byte_cnt <= '0;
            end else if (byte_valid) begin
                word_q   <= word_next;
                byte_cnt <= byte_last ? '0 : byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Loadable instruction memory for the Colorus CPU: registered fetch port
// with one cycle of latency plus a byte-stream program loader that holds
// the CPU while it runs.
// Optional feature macro: IMEM_CHECKSUM_EN (trailing mod-256 checksum byte).
//
// Stream handshake: a byte is taken on a rising edge where
// load_byte_valid && load_ready. load_ready depends only on the loader
// state, never on load_byte_valid; a byte held without ready just waits,
// and cycles without valid leave all loader state unchanged.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 28,
    parameter int                    ADDR_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_INSTR = DATA_WIDTH'(IMEM_NOP)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           address,
    input  logic                  fetch_en,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  instr_valid,
    output logic                  cpu_hold,
    input  logic                  load_start,
    input  logic [7:0]            load_byte,
    input  logic                  load_byte_valid,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  load_error,
    output loader_state_t         dbg_state
);

    localparam int          DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

`ifdef IMEM_CHECKSUM_EN
    localparam loader_state_t S_POST = S_CSUM;
`else
    localparam loader_state_t S_POST = S_DONE;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    loader_state_t         state;
    loader_state_t         state_next;
    logic [15:0]           word_cnt;
    logic [15:0]           word_idx;
    logic                  overflow;
    logic                  accept;
    logic                  idx_in_range;
    logic                  addr_in_range;
    logic                  err_next;
    logic                  mem_we;
    logic                  asm_last;
    logic                  asm_valid;
    logic [DATA_WIDTH-1:0] asm_word;
`ifdef IMEM_CHECKSUM_EN
    logic [7:0]            csum;
    logic                  csum_bad;
`endif

`ifdef IMEM_CHECKSUM_EN
    assign load_ready = (state == S_HDR0) || (state == S_HDR1) ||
                        (state == S_DATA) || (state == S_CSUM);
    assign csum_bad   = (state == S_CSUM) && accept && (load_byte != csum);
    assign err_next   = overflow || ((state == S_WRITE) && !idx_in_range) || csum_bad;
`else
    assign load_ready = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA);
    assign err_next   = overflow || ((state == S_WRITE) && !idx_in_range);
`endif

    assign accept        = load_byte_valid && load_ready;
    assign idx_in_range  = {16'd0, word_idx} < DEPTH_W;
    assign addr_in_range = {16'd0, address} < DEPTH_W;
    assign mem_we        = (state == S_WRITE) && asm_valid && idx_in_range;
    assign dbg_state     = state;

    instr_mem_loader_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      ((state == S_IDLE) && load_start),
        .byte_in    (load_byte),
        .byte_valid (accept && (state == S_DATA)),
        .byte_last  (asm_last),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    // Loader state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Loader next-state and hold/done decode
    always_comb begin
        state_next = state;
        cpu_hold   = 1'b1;
        load_done  = 1'b0;
        case (state)
            S_IDLE: begin
                cpu_hold = 1'b0;
                if (load_start) state_next = S_HDR0;
            end
            S_HDR0: begin
                if (accept) state_next = S_HDR1;
            end
            S_HDR1: begin
                if (accept) begin
                    state_next = ({load_byte, word_cnt[7:0]} == 16'd0) ? S_POST : S_DATA;
                end
            end
            S_DATA: begin
                if (asm_last) state_next = S_WRITE;
            end
            S_WRITE: begin
                state_next = (word_idx == word_cnt - 16'd1) ? S_POST : S_DATA;
            end
`ifdef IMEM_CHECKSUM_EN
            S_CSUM: begin
                if (accept) state_next = S_DONE;
            end
`endif
            S_DONE: begin
                cpu_hold   = 1'b0;
                load_done  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Word count, write index, overflow, checksum and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt   <= '0;
            word_idx   <= '0;
            overflow   <= 1'b0;
            load_error <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            if ((state == S_IDLE) && load_start) begin
                word_idx   <= '0;
                overflow   <= 1'b0;
                load_error <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
                csum       <= '0;
`endif
            end
            if (accept && (state == S_HDR0)) word_cnt[7:0]  <= load_byte;
            if (accept && (state == S_HDR1)) word_cnt[15:8] <= load_byte;
`ifdef IMEM_CHECKSUM_EN
            if (accept && (state != S_CSUM)) csum <= csum + load_byte;
`endif
            if (state == S_WRITE) begin
                if (!idx_in_range) overflow <= 1'b1;
                word_idx <= word_idx + 16'd1;
            end
            if ((state_next == S_DONE) && (state != S_DONE)) begin
                load_error <= err_next;
            end
        end
    end

    // Memory write port; the array itself is never reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx[ADDR_WIDTH-1:0]] <= asm_word;
        end
    end

    // Registered fetch port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instruction <= DEFAULT_INSTR;
            instr_valid <= 1'b0;
        end else if (fetch_en) begin
            if (cpu_hold) begin
                instruction <= DEFAULT_INSTR;
                instr_valid <= 1'b0;
            end else if (addr_in_range) begin
                instruction <= mem[address[ADDR_WIDTH-1:0]];
                instr_valid <= 1'b1;
            end else begin
                instruction <= DEFAULT_INSTR;
                instr_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: loads programs through the byte
// stream, keeps a model of the memory, and checks fetches through an
// expected queue. Follows the IMEM_CHECKSUM_EN setting of the build.
module tb_instr_mem_loader;
    import instr_mem_loader_pkg::*;

    localparam int DW    = 28;
    localparam int AW    = 8;
    localparam int DEPTH = 2 ** AW;
    localparam logic [DW-1:0] DEF = '0;

    logic          clk;
    logic          rst_n;
    logic [15:0]   address;
    logic          fetch_en;
    logic [DW-1:0] instruction;
    logic          instr_valid;
    logic          cpu_hold;
    logic          load_start;
    logic [7:0]    load_byte;
    logic          load_byte_valid;
    logic          load_ready;
    logic          load_done;
    logic          load_error;
    loader_state_t dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [31:0]   prog [300];
    logic [7:0]    sum_tb;
    logic [DW:0]   exp_q [$];

    instr_mem_loader #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .DEFAULT_INSTR (DEF)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .address         (address),
        .fetch_en        (fetch_en),
        .instruction     (instruction),
        .instr_valid     (instr_valid),
        .cpu_hold        (cpu_hold),
        .load_start      (load_start),
        .load_byte       (load_byte),
        .load_byte_valid (load_byte_valid),
        .load_ready      (load_ready),
        .load_done       (load_done),
        .load_error      (load_error),
        .dbg_state       (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drivers (called at a falling edge, return at a falling edge)
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int g = 0;
        int n = 0;
        while (gap_pct > 0 && g < 20 && $urandom_range(0, 99) < gap_pct) begin
            @(negedge clk);
            g++;
        end
        load_byte       = b;
        load_byte_valid = 1'b1;
        while (!load_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("byte_accept", 64'(load_ready), 64'd1);
        @(negedge clk);
        load_byte_valid = 1'b0;
        sum_tb          = sum_tb + b;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        sum_tb     = 8'd0;
    endtask

    task automatic fetch(input logic [15:0] a, input bit held);
        logic [DW:0] e;
        address  = a;
        fetch_en = 1'b1;
        if (held)                 exp_q.push_back({1'b0, DEF});
        else if (int'(a) < DEPTH) exp_q.push_back({1'b1, model_mem[a[AW-1:0]]});
        else                      exp_q.push_back({1'b1, DEF});
        @(negedge clk);
        fetch_en = 1'b0;
        e = exp_q.pop_front();
        check($sformatf("fetch_instr[%0d]", a), 64'(instruction), 64'(e[DW-1:0]));
        check($sformatf("fetch_valid[%0d]", a), 64'(instr_valid), 64'(e[DW]));
    endtask

    task automatic send_body(input int n, input int gap_pct);
        logic [31:0] w;
        send_byte(n[7:0], gap_pct);
        send_byte(n[15:8], gap_pct);
        for (int i = 0; i < n; i++) begin
            w = prog[i];
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_pct);
            if (i < DEPTH) model_mem[i] = w[DW-1:0];
        end
    endtask

    task automatic finish_load(input bit bad_csum, input bit exp_err);
        int  c = 0;
        bit  err = exp_err;
`ifdef IMEM_CHECKSUM_EN
        logic [7:0] cs;
        cs = bad_csum ? (sum_tb ^ 8'h5A) : sum_tb;
        err = exp_err | bad_csum;
        send_byte(cs, 0);
`else
        load_byte       = 8'hA5;
        load_byte_valid = 1'b1;
`endif
        while (!load_done && c < 32) begin
`ifndef IMEM_CHECKSUM_EN
            check("extra_byte_refused", 64'(load_ready), 64'd0);
`endif
            @(negedge clk);
            c++;
        end
        check("done_pulse", 64'(load_done), 64'd1);
        check("done_error", 64'(load_error), 64'(err));
        check("done_hold_low", 64'(cpu_hold), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(load_done), 64'd0);
        check("back_idle", 64'(dbg_state), 64'(S_IDLE));
        check("idle_not_ready", 64'(load_ready), 64'd0);
        check("error_sticky", 64'(load_error), 64'(err));
        load_byte_valid = 1'b0;
    endtask

    task automatic run_load(input int n, input int gap_pct, input bit bad_csum, input bit exp_err);
        start_load();
        send_body(n, gap_pct);
        finish_load(bad_csum, exp_err);
    endtask

    initial begin
        rst_n = 1'b0; address = '0; fetch_en = 1'b0; load_start = 1'b0;
        load_byte = '0; load_byte_valid = 1'b0; sum_tb = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = DEF;

        // 1: reset state and out-of-range fetch
        repeat (3) @(negedge clk);
        check("rst_instr", 64'(instruction), 64'(DEF));
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_hold", 64'(cpu_hold), 64'd0);
        check("rst_ready", 64'(load_ready), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_error", 64'(load_error), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        fetch(16'd300, 1'b0);
        @(negedge clk);
        check("fetch_hold_valid", 64'(instr_valid), 64'd1);
        fetch(16'hFFFF, 1'b0);

        // 2: three-word load, top byte carries bits to be discarded
        prog[0] = 32'h01000001; prog[1] = 32'h02000002; prog[2] = 32'hFFFFFFFF;
        start_load();
        check("hold_in_load", 64'(cpu_hold), 64'd1);
        fetch(16'd0, 1'b1);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("start_ignored", 64'(dbg_state), 64'(S_HDR0));
        send_body(3, 0);
        finish_load(1'b0, 1'b0);
        for (int a = 0; a < 3; a++) fetch(16'(a), 1'b0);

        // 3: overflow load of DEPTH+2 words
        for (int i = 0; i < DEPTH + 2; i++) prog[i] = $urandom();
        run_load(DEPTH + 2, 0, 1'b0, 1'b1);
        fetch(16'd0, 1'b0);
        fetch(16'd100, 1'b0);
        fetch(16'(DEPTH - 1), 1'b0);
        fetch(16'(DEPTH), 1'b0);

        // 4: load with long valid gaps; error cleared by the new start
        for (int i = 0; i < 10; i++) prog[i] = $urandom();
        run_load(10, 70, 1'b0, 1'b0);
        for (int a = 0; a < 11; a++) fetch(16'(a), 1'b0);

        // 5: reset after six bytes of a three-word load
        for (int i = 0; i < 3; i++) prog[i] = $urandom();
        start_load();
        send_byte(8'd3, 0);
        send_byte(8'd0, 0);
        for (int k = 0; k < 4; k++) send_byte(prog[0][8*k +: 8], 0);
        model_mem[0] = prog[0][DW-1:0];
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_state", 64'(dbg_state), 64'(S_IDLE));
        check("abort_hold", 64'(cpu_hold), 64'd0);
        check("abort_ready", 64'(load_ready), 64'd0);
        check("abort_valid", 64'(instr_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        fetch(16'd0, 1'b0);
        fetch(16'd1, 1'b0);
        fetch(16'd2, 1'b0);

        // 6: checksum handling, or refusal of a trailing byte
        prog[0] = 32'h0ABCDEF1; prog[1] = 32'h00123456;
        run_load(2, 0, 1'b1, 1'b0);
        run_load(2, 0, 1'b0, 1'b0);
        run_load(0, 0, 1'b0, 1'b0);
        fetch(16'd0, 1'b0);
        fetch(16'd1, 1'b0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
